// File: rtl/ir_beacon_tx.sv
// IR beacon transmitter: keyed square-wave bursts at one of three station frequencies.
// Optional IR_CARRIER_EN gates the code waveform with a 38 kHz carrier.
module ir_beacon_tx #(
  parameter int CLK_HZ        = 100_000_000,
  parameter int FREQ0_HZ      = 100,
  parameter int FREQ1_HZ      = 1_000,
  parameter int FREQ2_HZ      = 10_000,
  parameter int BURST_PERIODS = 64,
  parameter int GAP_CYCLES    = 1_000_000,
  parameter int NUM_BURSTS    = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [1:0] sel,
  input  logic       abort,
  output logic       ir_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int HP0    = CLK_HZ / (2 * FREQ0_HZ);
  localparam int HP1    = CLK_HZ / (2 * FREQ1_HZ);
  localparam int HP2    = CLK_HZ / (2 * FREQ2_HZ);
  localparam int HP01   = (HP0 > HP1) ? HP0 : HP1;
  localparam int HP_MAX = (HP01 > HP2) ? HP01 : HP2;
  localparam int HP_W   = $clog2(HP_MAX) + 1;
  localparam int HALF_N = 2 * BURST_PERIODS;
  localparam int HALF_W = $clog2(HALF_N) + 1;
  localparam int BC_W   = $clog2(NUM_BURSTS + 1) + 1;
  localparam int GAP_W  = $clog2(GAP_CYCLES) + 1;

  if (HP0 < 1 || HP1 < 1 || HP2 < 1) begin : g_bad_hp
    $error("ir_beacon_tx: a station half-period is below one clock");
  end

  typedef enum logic [1:0] {IDLE, BURST, GAP, FIN} state_t;

  state_t            state, state_n;
  logic [1:0]        sel_q, sel_n;
  logic [HP_W-1:0]   hp_cnt, hp_n, hp_end;
  logic [HALF_W-1:0] half_cnt, half_n;
  logic [BC_W-1:0]   burst_cnt, burst_n, burst_inc;
  logic [GAP_W-1:0]  gap_cnt, gap_n;
  logic              wave, wave_n;
  logic              busy_n, done_n, err_n, ir_n;

  always_comb begin
    case (sel_q)
      2'd0:    hp_end = HP_W'(HP0 - 1);
      2'd1:    hp_end = HP_W'(HP1 - 1);
      default: hp_end = HP_W'(HP2 - 1);
    endcase
  end

  always_comb begin
    state_n   = state;
    sel_n     = sel_q;
    hp_n      = hp_cnt;
    half_n    = half_cnt;
    burst_n   = burst_cnt;
    gap_n     = gap_cnt;
    wave_n    = 1'b0;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    err_n     = 1'b0;
    burst_inc = burst_cnt + BC_W'(1);
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          if (sel == 2'd3) begin
            err_n = 1'b1;
          end else begin
            sel_n   = sel;
            state_n = BURST;
            hp_n    = '0;
            half_n  = '0;
            burst_n = '0;
            wave_n  = 1'b1;
            busy_n  = 1'b1;
          end
        end
      end
      BURST: begin
        busy_n = 1'b1;
        if (hp_cnt == hp_end) begin
          hp_n = '0;
          if (half_cnt == HALF_W'(HALF_N - 1)) begin
            burst_n = burst_inc;
            half_n  = '0;
            if (burst_inc < BC_W'(NUM_BURSTS)) begin
              state_n = GAP;
              gap_n   = '0;
            end else begin
              state_n = FIN;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end
          end else begin
            half_n = half_cnt + HALF_W'(1);
            wave_n = ~wave;
          end
        end else begin
          hp_n   = hp_cnt + HP_W'(1);
          wave_n = wave;
        end
      end
      GAP: begin
        busy_n = 1'b1;
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          state_n = BURST;
          hp_n    = '0;
          half_n  = '0;
          wave_n  = 1'b1;
        end else begin
          gap_n = gap_cnt + GAP_W'(1);
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Cancel overrides everything once a transmission is under way
    if (abort && state != IDLE) begin
      state_n = IDLE;
      wave_n  = 1'b0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
    end
  end

`ifdef IR_CARRIER_EN
  localparam int CHP  = CLK_HZ / 76_000;
  localparam int CW   = $clog2(CHP) + 1;

  if (CHP < 1) begin : g_bad_chp
    $error("ir_beacon_tx: carrier half-period is below one clock");
  end

  logic [CW-1:0] c_cnt, c_cnt_n;
  logic          car, car_n;

  always_comb begin
    c_cnt_n = c_cnt;
    car_n   = car;
    if (state_n == BURST && state != BURST) begin
      c_cnt_n = '0;
      car_n   = 1'b1;
    end else if (c_cnt == CW'(CHP - 1)) begin
      c_cnt_n = '0;
      car_n   = ~car;
    end else begin
      c_cnt_n = c_cnt + CW'(1);
    end
    ir_n = wave_n & car_n;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      c_cnt <= '0;
      car   <= 1'b0;
    end else begin
      c_cnt <= c_cnt_n;
      car   <= car_n;
    end
  end
`else
  always_comb ir_n = wave_n;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      sel_q     <= '0;
      hp_cnt    <= '0;
      half_cnt  <= '0;
      burst_cnt <= '0;
      gap_cnt   <= '0;
      wave      <= 1'b0;
      ir_out    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      sel_q     <= sel_n;
      hp_cnt    <= hp_n;
      half_cnt  <= half_n;
      burst_cnt <= burst_n;
      gap_cnt   <= gap_n;
      wave      <= wave_n;
      ir_out    <= ir_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_ir_beacon_tx.sv
// Directed bench for ir_beacon_tx at a 1 MHz clock, 4-period bursts,
// 2000-cycle gaps and two bursts per transmission.
module tb_ir_beacon_tx;

  localparam int GAP = 2000;

  logic       clk   = 1'b0;
  logic       clr   = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] sel   = 2'd0;
  logic       ir_out, busy, done, err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ir_beacon_tx #(
    .CLK_HZ       (1_000_000),
    .FREQ0_HZ     (1_000),
    .FREQ1_HZ     (1_000),
    .FREQ2_HZ     (10_000),
    .BURST_PERIODS(4),
    .GAP_CYCLES   (GAP),
    .NUM_BURSTS   (2)
  ) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .sel   (sel),
    .abort (abort),
    .ir_out(ir_out),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {ir_out,busy,done,err} k cycles after the start cycle
  function automatic logic [3:0] exp_out(input int k, input int hp,
                                         input int ab);
    int   l, t, j;
    logic ir;
    l  = 8 * hp;
    t  = 2 * l + GAP;
    j  = -1;
    ir = 1'b0;
    if (k >= 1 && k <= l) j = k - 1;
    else if (k >= l + GAP + 1 && k <= t) j = k - l - GAP - 1;
    if (j >= 0) ir = ((j / hp) % 2) == 0;
`ifdef IR_CARRIER_EN
    if (j >= 0) ir = ir & (((j / 13) % 2) == 0);
`endif
    if (ab > 0 && k > ab) return 4'b0000;
    return {ir, (k >= 1 && k <= t), (k == t + 1), 1'b0};
  endfunction

  task automatic run_tx(input logic [1:0] s, input int hp, input int ab,
                        input int rs, input int ncyc);
    sel   = s;
    start = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      step();
      start = 1'b0;
      abort = 1'b0;
      check($sformatf("tx%0d k=%0d", s, k),
            {ir_out, busy, done, err}, exp_out(k, hp, ab));
      if (k == ab) abort = 1'b1;
      if (k == rs) begin
        start = 1'b1;
        sel   = (s == 2'd2) ? 2'd1 : 2'd2;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    sel   = 2'd0;
  endtask

  initial begin
    repeat (3) step();
    check("reset", {ir_out, busy, done, err}, 4'b0000);
    clr = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      check("idle", {ir_out, busy, done, err}, 4'b0000);
    end

    run_tx(2'd0, 500, 0, 100, 10005);
    run_tx(2'd2, 50, 0, 100, 2805);

    sel   = 2'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    check("bad_sel", {ir_out, busy, done, err}, 4'b0001);
    step();
    check("bad_sel_end", {ir_out, busy, done, err}, 4'b0000);

    abort = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("bad_sel_abort", {ir_out, busy, done, err}, 4'b0000);

    sel   = 2'd0;
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("start_abort", {ir_out, busy, done, err}, 4'b0000);
      step();
    end

    run_tx(2'd2, 50, 1200, 0, 3000);
    run_tx(2'd0, 500, 1200, 0, 1300);

    sel   = 2'd2;
    start = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      step();
      start = 1'b0;
    end
    check("pre_clr", {ir_out, busy, done, err}, exp_out(21, 50, 0));
    #3;
    clr = 1'b0;
    #1;
    check("async_clr", {ir_out, busy, done, err}, 4'b0000);
    #1;
    clr = 1'b1;
    step();
    check("post_clr", {ir_out, busy, done, err}, 4'b0000);
    run_tx(2'd2, 50, 0, 0, 2805);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
